// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU with single-cycle base ops and bit-serial RV32M multiply/divide.
module iter_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            out_bit0,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SEQ  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic [4:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;

    logic              accept, is_mul, is_div, lhs_neg, rhs_neg, div_zero, div_ovf, ge;
    logic [XLEN-1:0]   lhs_mag, rhs_mag, base_res, mul_res, div_res, rem_step, quo_step;
    logic [2*XLEN-1:0] prod_step, prod_fin;
    logic [XLEN:0]     shifted, diff;
    logic [SW-1:0]     shamt;

    assign in_ready  = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == DONE;
    assign out       = out_q;
    assign out_bit0  = out_q[0];
    assign busy      = state_q == MUL || state_q == DIV;

    // MULHSU treats only lhs as signed; DIVU/REMU (op[0]=1) are unsigned
    assign is_mul   = op[4:2] == 3'b100;
    assign is_div   = op[4:2] == 3'b101;
    assign lhs_neg  = lhs[XLEN-1] && ((is_mul && op[1:0] != 2'b11) || (is_div && !op[0]));
    assign rhs_neg  = rhs[XLEN-1] && ((is_mul && !op[1]) || (is_div && !op[0]));
    assign lhs_mag  = lhs_neg ? -lhs : lhs;
    assign rhs_mag  = rhs_neg ? -rhs : rhs;
    assign div_zero = rhs == '0;
    assign div_ovf  = !op[0] && lhs == INT_MIN && rhs == '1;
    assign shamt    = rhs[SW-1:0];

    always_comb begin
        case (op)
            OP_ADD:  base_res = lhs + rhs;
            OP_SUB:  base_res = lhs - rhs;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, lhs < rhs};
            OP_XOR:  base_res = lhs ^ rhs;
            OP_OR:   base_res = lhs | rhs;
            OP_AND:  base_res = lhs & rhs;
            OP_SLL:  base_res = lhs << shamt;
            OP_SRL:  base_res = lhs >> shamt;
            OP_SRA:  base_res = $signed(lhs) >>> shamt;
            OP_SEQ:  base_res = {{(XLEN-1){1'b0}}, lhs == rhs};
            default: base_res = '0;
        endcase
    end

    assign prod_step = mplier_q[0] ? prod_q + mcand_q : prod_q;
    assign prod_fin  = neg_q ? -prod_step : prod_step;
    assign mul_res   = op_q == OP_MUL ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvsr_q};
    assign ge       = !diff[XLEN];
    assign rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ge};
    assign div_res  = op_q[1] ? (rneg_q ? -rem_step : rem_step) : (neg_q ? -quo_step : quo_step);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                MUL: begin
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    prod_d   = prod_step;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_d   = mul_res;
                        state_d = DONE;
                    end
                end
                DIV: begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        out_d   = div_res;
                        state_d = DONE;
                    end
                end
                default: begin
                    if (state_q == DONE && out_ready)
                        state_d = IDLE;
                    if (accept) begin
                        op_d   = op;
                        neg_d  = lhs_neg ^ rhs_neg;
                        rneg_d = lhs_neg;
                        if (is_mul) begin
                            mcand_d  = {{XLEN{1'b0}}, lhs_mag};
                            mplier_d = rhs_mag;
                            prod_d   = '0;
                            cnt_d    = CW'(XLEN);
                            state_d  = MUL;
                        end else if (is_div && div_zero) begin
                            out_d   = op[1] ? lhs : '1;
                            state_d = DONE;
                        end else if (is_div && div_ovf) begin
                            out_d   = op[1] ? '0 : lhs;
                            state_d = DONE;
                        end else if (is_div) begin
                            quo_d   = lhs_mag;
                            rem_d   = '0;
                            dvsr_d  = rhs_mag;
                            cnt_d   = CW'(XLEN);
                            state_d = DIV;
                        end else begin
                            out_d   = base_res;
                            state_d = DONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed and randomized checks of iter_alu against an arithmetic reference model.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] lhs = '0;
    logic [31:0] rhs = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        out_bit0;
    logic        busy;
    int          n_checks = 0;
    int          n_errors = 0;

    iter_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_bit0(out_bit0), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, r;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = b[4:0];
        case (o)
            5'd1:  r = sa + sb;
            5'd2:  r = sa - sb;
            5'd3:  r = (sa < sb) ? 1 : 0;
            5'd4:  r = (ua < ub) ? 1 : 0;
            5'd5:  r = ua ^ ub;
            5'd6:  r = ua | ub;
            5'd7:  r = ua & ub;
            5'd8:  r = ua << sh;
            5'd9:  r = ua >> sh;
            5'd10: r = sa >>> sh;
            5'd11: r = (a == b) ? 1 : 0;
            5'd16: r = sa * sb;
            5'd17: begin p = sa * sb; r = longint'(p >> 32); end
            5'd18: begin p = sa * ub; r = longint'(p >> 32); end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; r = longint'(p >> 32); end
            5'd20: r = (b == 0) ? -1 : (sb == -1 && sa == -(64'sd1 <<< 31)) ? sa : sa / sb;
            5'd21: r = (b == 0) ? -1 : ua / ub;
            5'd22: r = (b == 0) ? sa : (sb == -1) ? 0 : sa % sb;
            5'd23: r = (b == 0) ? ua : ua % ub;
            default: r = 0;
        endcase
        p = r;
        return p[31:0];
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 5'd16 && o <= 5'd19) return 33;
        if (o >= 5'd20 && o <= 5'd23) begin
            if (b == 0) return 1;
            if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        int          lat, cyc;
        e   = model(o, a, b);
        lat = exp_lat(o, a, b);
        @(negedge clk);
        op = o; lhs = a; rhs = b; in_valid = 1'b1;
        #1 check("in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        check("busy", {31'b0, busy}, {31'b0, lat > 1});
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("lat op%0d", o), cyc, lat);
        check($sformatf("out op%0d", o), out, e);
        check("bit0", {31'b0, out_bit0}, {31'b0, e[0]});
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops[22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd11, 5'd12, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd31};
        int cyc;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out", out, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;

        run_op(5'd1, 32'h7FFF_FFFF, 32'd1);
        run_op(5'd10, 32'h8000_0000, 32'd4);
        run_op(5'd17, 32'hFFFF_FFFE, 32'd3);
        run_op(5'd16, 32'hFFFF_FFFE, 32'd3);
        run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(5'd20, 32'hFFFF_FFF9, 32'd2);
        run_op(5'd22, 32'hFFFF_FFF9, 32'd2);
        run_op(5'd21, 32'd7, 32'd0);
        run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(5'd31, 32'h1234_5678, 32'h9ABC_DEF0);

        for (int i = 0; i < 50; i++)
            run_op(ops[$urandom_range(0, 21)], rnd_opnd(), rnd_opnd());

        // Backpressure: result held, then a queued ADD accepted on release
        @(negedge clk);
        out_ready = 1'b0;
        op = 5'd21; lhs = 32'd100; rhs = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("bp lat", cyc, 33);
        op = 5'd1; lhs = 32'd5; rhs = 32'd6; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp hold out", out, 32'd14);
            check("bp hold valid", {31'b0, out_valid}, 32'd1);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp release ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp next valid", {31'b0, out_valid}, 32'd1);
        check("bp next out", out, 32'd11);

        // Flush in the tenth MUL cycle while a new op is offered
        @(negedge clk);
        op = 5'd16; lhs = 32'd9; rhs = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; op = 5'd1; lhs = 32'd1; rhs = 32'd1; in_valid = 1'b1;
        #1 check("flush in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush valid", {31'b0, out_valid}, 32'd0);
        check("flush busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("flush no out", {31'b0, seen}, 32'd0);
        run_op(5'd2, 32'd3, 32'd5);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 5'd20; lhs = 32'd1000; rhs = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", {31'b0, out_valid}, 32'd0);
        check("arst out", out, 32'd0);
        check("arst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid | busy;
        end
        check("arst quiet", {31'b0, seen}, 32'd0);
        run_op(5'd31, 32'hFFFF_FFFF, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
